// File: rtl/updown_count_monitor.sv
// rtl/updown_count_monitor.sv - receive-side step classifier for an up/down counter bus
// Decodes each valid sample as up/down/hold/load, flags illegal jumps and counts wraps.
module updown_count_monitor #(
  parameter int WIDTH  = 5,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              valid,
  output logic              dir_up,
  output logic              dir_dn,
  output logic              hold,
  output logic              load_p,
  output logic              wrap_up_p,
  output logic              wrap_dn_p,
  output logic              err,
  output logic [WRAP_W-1:0] up_wraps,
  output logic [WRAP_W-1:0] dn_wraps,
  output logic [WIDTH-1:0]  last_count
);

  typedef enum logic [2:0] {S_EMPTY, S_HOLD, S_UP, S_DN, S_ERR} state_t;

  localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  ZERO  = '0;
  localparam logic [WIDTH-1:0]  ALL1  = '1;
  localparam logic [WRAP_W-1:0] W_ONE = WRAP_W'(1);
  localparam logic [WRAP_W-1:0] W_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] last_inc;
  logic [WIDTH-1:0] last_dec;

  // Modulo neighbours of the last sample; carry/borrow is dropped on purpose.
  assign last_inc = last_count + ONE;
  assign last_dec = last_count - ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_EMPTY;
      dir_up     <= 1'b0;
      dir_dn     <= 1'b0;
      hold       <= 1'b0;
      load_p     <= 1'b0;
      wrap_up_p  <= 1'b0;
      wrap_dn_p  <= 1'b0;
      err        <= 1'b0;
      up_wraps   <= '0;
      dn_wraps   <= '0;
      last_count <= '0;
    end else begin
      load_p    <= 1'b0;
      wrap_up_p <= 1'b0;
      wrap_dn_p <= 1'b0;
      if (valid) begin
        case (state)
          S_EMPTY: begin
            last_count <= count_in;
            state      <= S_HOLD;
            hold       <= 1'b1;
          end
          S_ERR: begin
            last_count <= count_in;
          end
          default: begin
            if (count_in == last_inc) begin
              last_count <= count_in;
              state      <= S_UP;
              dir_up     <= 1'b1;
              dir_dn     <= 1'b0;
              hold       <= 1'b0;
              if (last_count == ALL1) begin
                wrap_up_p <= 1'b1;
                if (up_wraps != W_MAX) up_wraps <= up_wraps + W_ONE;
              end
            end else if (count_in == last_dec) begin
              last_count <= count_in;
              state      <= S_DN;
              dir_up     <= 1'b0;
              dir_dn     <= 1'b1;
              hold       <= 1'b0;
              if (last_count == ZERO) begin
                wrap_dn_p <= 1'b1;
                if (dn_wraps != W_MAX) dn_wraps <= dn_wraps + W_ONE;
              end
            end else if (count_in == last_count) begin
              last_count <= count_in;
              state      <= S_HOLD;
              dir_up     <= 1'b0;
              dir_dn     <= 1'b0;
              hold       <= 1'b1;
            end else if (count_in == ZERO || count_in == ALL1) begin
              last_count <= count_in;
              state      <= S_HOLD;
              dir_up     <= 1'b0;
              dir_dn     <= 1'b0;
              hold       <= 1'b1;
              load_p     <= 1'b1;
            end else begin
              // Illegal jump: last_count keeps the pre-error value on this sample.
              state  <= S_ERR;
              dir_up <= 1'b0;
              dir_dn <= 1'b0;
              hold   <= 1'b0;
              err    <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_count_monitor.sv
// tb/tb_updown_count_monitor.sv - scoreboard bench for updown_count_monitor
// Two DUTs (WRAP_W=8 and WRAP_W=2) share stimulus; a behavioural model feeds a queue.
module tb_updown_count_monitor;

  localparam int W = 5;
  localparam int M = 32;

  typedef struct {
    int dir_up, dir_dn, hold, load_p, wrap_up_p, wrap_dn_p, err;
    int up8, dn8, up2, dn2, last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] count_in = '0;

  logic         a_up, a_dn, a_hold, a_load, a_wu, a_wd, a_err;
  logic [7:0]   a_upw, a_dnw;
  logic [W-1:0] a_last;
  logic         b_up, b_dn, b_hold, b_load, b_wu, b_wd, b_err;
  logic [1:0]   b_upw, b_dnw;
  logic [W-1:0] b_last;

  updown_count_monitor #(.WIDTH(W), .WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .valid(valid),
    .dir_up(a_up), .dir_dn(a_dn), .hold(a_hold), .load_p(a_load),
    .wrap_up_p(a_wu), .wrap_dn_p(a_wd), .err(a_err),
    .up_wraps(a_upw), .dn_wraps(a_dnw), .last_count(a_last)
  );

  updown_count_monitor #(.WIDTH(W), .WRAP_W(2)) dut2 (
    .clk(clk), .reset(reset), .count_in(count_in), .valid(valid),
    .dir_up(b_up), .dir_dn(b_dn), .hold(b_hold), .load_p(b_load),
    .wrap_up_p(b_wu), .wrap_dn_p(b_wd), .err(b_err),
    .up_wraps(b_upw), .dn_wraps(b_dnw), .last_count(b_last)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: plain integers and a few booleans.
  int   m_started, m_bad, m_last;
  exp_t m;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic step(input bit rst, input bit v, input int cin);
    int d;
    @(negedge clk);
    reset    = rst;
    valid    = v;
    count_in = W'(cin);
    m.load_p = 0; m.wrap_up_p = 0; m.wrap_dn_p = 0;
    if (rst) begin
      m = '{default: 0};
      m_started = 0; m_bad = 0; m_last = 0;
    end else if (v) begin
      if (!m_started) begin
        m_started = 1; m_last = cin;
        m.hold = 1; m.dir_up = 0; m.dir_dn = 0;
      end else if (m_bad) begin
        m_last = cin;
      end else begin
        d = (cin - m_last + M) % M;
        if (d == 1) begin
          m.dir_up = 1; m.dir_dn = 0; m.hold = 0;
          if (m_last == M - 1) begin
            m.wrap_up_p = 1; m.up8 = sat(m.up8, 255); m.up2 = sat(m.up2, 3);
          end
          m_last = cin;
        end else if (d == M - 1) begin
          m.dir_up = 0; m.dir_dn = 1; m.hold = 0;
          if (m_last == 0) begin
            m.wrap_dn_p = 1; m.dn8 = sat(m.dn8, 255); m.dn2 = sat(m.dn2, 3);
          end
          m_last = cin;
        end else if (d == 0) begin
          m.dir_up = 0; m.dir_dn = 0; m.hold = 1;
        end else if (cin == 0 || cin == M - 1) begin
          m.dir_up = 0; m.dir_dn = 0; m.hold = 1; m.load_p = 1;
          m_last = cin;
        end else begin
          m_bad = 1; m.err = 1;
          m.dir_up = 0; m.dir_dn = 0; m.hold = 0;
        end
      end
    end
    m.last = m_last;
    q.push_back(m);
  endtask

  task automatic samples(input int a[]);
    foreach (a[i]) step(1'b0, 1'b1, a[i]);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dir_up",    a_up,   e.dir_up);
        chk("dir_dn",    a_dn,   e.dir_dn);
        chk("hold",      a_hold, e.hold);
        chk("load_p",    a_load, e.load_p);
        chk("wrap_up_p", a_wu,   e.wrap_up_p);
        chk("wrap_dn_p", a_wd,   e.wrap_dn_p);
        chk("err",       a_err,  e.err);
        chk("up_wraps",  a_upw,  e.up8);
        chk("dn_wraps",  a_dnw,  e.dn8);
        chk("last_count", a_last, e.last);
        chk("w2_up_wraps", b_upw, e.up2);
        chk("w2_dn_wraps", b_dnw, e.dn2);
        chk("w2_wrap_up_p", b_wu, e.wrap_up_p);
        chk("w2_err",    b_err,  e.err);
        chk("w2_last",   b_last, e.last);
      end
    end
  end

  initial begin : stimulus
    int pick, nxt;
    m = '{default: 0};
    m_started = 0; m_bad = 0; m_last = 0;
    step(1'b1, 1'b0, 0);
    samples('{3, 4, 5});
    step(1'b1, 1'b0, 0);
    samples('{30, 31, 0});
    step(1'b0, 1'b0, 9);
    step(1'b1, 1'b0, 0);
    samples('{2, 1, 0, 31});
    step(1'b1, 1'b0, 0);
    samples('{10, 31});
    step(1'b1, 1'b0, 0);
    samples('{12, 0, 7, 8, 9});
    step(1'b1, 1'b0, 0);
    samples('{4, 5, 6});
    step(1'b1, 1'b1, 7);
    samples('{8, 9});
    step(1'b1, 1'b0, 0);
    samples('{31, 0, 1, 2, 3});
    for (int k = 0; k < 5; k++) begin
      for (int c = 4; c < 32; c++) step(1'b0, 1'b1, c);
      step(1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 17);
    end
    for (int k = 0; k < 3000; k++) begin
      pick = $urandom_range(0, 99);
      case (pick % 6)
        0, 1:    nxt = (m_last + 1) % M;
        2:       nxt = (m_last + M - 1) % M;
        3:       nxt = m_last;
        4:       nxt = (pick < 50) ? 0 : M - 1;
        default: nxt = $urandom_range(0, M - 1);
      endcase
      if (pick >= 98) step(1'b1, $urandom_range(0, 1) == 1, nxt);
      else            step(1'b0, $urandom_range(0, 3) != 0, nxt);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
